player_motion: RTL and testbench

Two-axis, parametrised player motion controller for the VGA game datapath. Once per frame it turns the keyboard `keycode` into horizontal acceleration and deceleration, plus jump-and-gravity vertical motion. Position is clamped to a configurable playfield. Outputs feed the sprite/colour mapper and collision logic alongside the other game objects.

---
 rtl/player_motion_if.sv | 26 ++
 rtl/player_motion.sv | 168 ++++++++++++++++
 tb/tb_player_motion.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/player_motion_if.sv
// Player motion bundle: keycode into the controller, position/velocity/status back out.
// No valid/ready here: every signal is a level, and outputs hold steady between frame ticks.
interface player_motion_if #(
  parameter int W = 10
);
  logic [7:0]   keycode;
  logic [W-1:0] player_X_Pos;
  logic [W-1:0] player_Y_Pos;
  logic [W-1:0] player_X_Motion;
  logic [W-1:0] player_Y_Motion;
  logic         airborne;
  logic         at_wall;
  logic [1:0]   y_state;

  modport master (
    output keycode,
    input  player_X_Pos, player_Y_Pos, player_X_Motion, player_Y_Motion,
    input  airborne, at_wall, y_state
  );

  modport slave (
    input  keycode,
    output player_X_Pos, player_Y_Pos, player_X_Motion, player_Y_Motion,
    output airborne, at_wall, y_state
  );
endinterface

// File: rtl/player_motion.sv
// Per-frame player motion: horizontal accel/decel with wall clamping, and a
// GROUND/RISE/FALL vertical FSM for jump and gravity, all advanced on one frame tick.
module player_motion #(
  parameter int         W         = 10,
  parameter int         X_MIN     = 0,
  parameter int         X_MAX     = 639,
  parameter int         Y_MIN     = 0,
  parameter int         Y_MAX     = 479,
  parameter int         X_CENTER  = 320,
  parameter int         SIZE      = 4,
  parameter int         X_ACCEL   = 1,
  parameter int         MAX_SPEED = 4,
  parameter int         JUMP_VEL  = 8,
  parameter int         GRAVITY   = 1,
  parameter int         MAX_FALL  = 8,
  parameter logic [7:0] KEY_LEFT  = 8'd80,
  parameter logic [7:0] KEY_RIGHT = 8'd79,
  parameter logic [7:0] KEY_JUMP  = 8'd82
) (
  input logic             Clk,
  input logic             Reset_n,
  input logic             frame_clk,
  player_motion_if.slave  bus
);

  // Two guard bits so position + velocity can be compared against bounds without wrapping.
  localparam int XW = W + 2;
  typedef logic signed [XW-1:0] sw_t;

  localparam sw_t ACC    = sw_t'(X_ACCEL);
  localparam sw_t VMAX   = sw_t'(MAX_SPEED);
  localparam sw_t X_LO   = sw_t'(X_MIN + SIZE);
  localparam sw_t X_HI   = sw_t'(X_MAX - SIZE);
  localparam sw_t Y_GND  = sw_t'(Y_MAX - SIZE);
  localparam sw_t Y_CEIL = sw_t'(Y_MIN + SIZE);
  localparam sw_t GRAV   = sw_t'(GRAVITY);
  localparam sw_t JUMP   = sw_t'(JUMP_VEL);
  localparam sw_t FMAX   = sw_t'(MAX_FALL);

  typedef enum logic [1:0] {GROUND = 2'd0, RISE = 2'd1, FALL = 2'd2} y_state_t;

  logic [W-1:0] x_pos, y_pos, x_vel, y_vel;
  y_state_t     state;
  logic         airborne_q, at_wall_q;
  logic         sync1, sync2, delay;
  logic [2:0]   warm;
  logic         tick;

  logic [W-1:0] x_pos_d, x_vel_d, y_pos_d, y_vel_d;
  logic         wall_d;
  y_state_t     state_d;
  sw_t          vx, vx_n, x_n, vy, vy_n, y_n;

  // warm[2] keeps a frame_clk already high at reset release from looking like a rising edge.
  assign tick = sync2 & ~delay & warm[2];

  always_comb begin
    vx      = sw_t'(signed'(x_vel));
    vx_n    = vx;
    if (bus.keycode == KEY_LEFT) begin
      vx_n = ((vx - ACC) < -VMAX) ? -VMAX : (vx - ACC);
    end else if (bus.keycode == KEY_RIGHT) begin
      vx_n = ((vx + ACC) > VMAX) ? VMAX : (vx + ACC);
    end else if (vx > ACC) begin
      vx_n = vx - ACC;
    end else if (vx < -ACC) begin
      vx_n = vx + ACC;
    end else begin
      vx_n = '0;
    end
    x_n     = sw_t'(x_pos) + vx_n;
    x_pos_d = W'(x_n);
    x_vel_d = W'(vx_n);
    wall_d  = 1'b0;
    if (x_n < X_LO) begin
      x_pos_d = W'(X_LO);
      x_vel_d = '0;
      wall_d  = 1'b1;
    end else if (x_n > X_HI) begin
      x_pos_d = W'(X_HI);
      x_vel_d = '0;
      wall_d  = 1'b1;
    end
  end

  always_comb begin
    vy      = sw_t'(signed'(y_vel));
    vy_n    = vy + GRAV;
    y_n     = sw_t'(y_pos) + vy_n;
    y_pos_d = y_pos;
    y_vel_d = y_vel;
    state_d = state;
    case (state)
      RISE: begin
        if (y_n < Y_CEIL) begin
          y_pos_d = W'(Y_CEIL);
          y_vel_d = '0;
          state_d = FALL;
        end else begin
          y_pos_d = W'(y_n);
          y_vel_d = W'(vy_n);
          if (vy_n >= 0) state_d = FALL;
        end
      end
      FALL: begin
        if (vy_n > FMAX) vy_n = FMAX;
        y_n = sw_t'(y_pos) + vy_n;
        if (y_n >= Y_GND) begin
          y_pos_d = W'(Y_GND);
          y_vel_d = '0;
          state_d = GROUND;
        end else begin
          y_pos_d = W'(y_n);
          y_vel_d = W'(vy_n);
        end
      end
      default: begin
        y_pos_d = W'(Y_GND);
        y_vel_d = '0;
        state_d = GROUND;
        if (bus.keycode == KEY_JUMP) begin
          y_pos_d = W'(Y_GND - JUMP);
          y_vel_d = W'(-JUMP);
          state_d = RISE;
        end
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      delay      <= 1'b0;
      warm       <= '0;
      x_pos      <= W'(X_CENTER);
      x_vel      <= '0;
      y_pos      <= W'(Y_GND);
      y_vel      <= '0;
      state      <= GROUND;
      airborne_q <= 1'b0;
      at_wall_q  <= 1'b0;
    end else begin
      sync1 <= frame_clk;
      sync2 <= sync1;
      delay <= sync2;
      warm  <= {warm[1:0], 1'b1};
      if (tick) begin
        x_pos      <= x_pos_d;
        x_vel      <= x_vel_d;
        at_wall_q  <= wall_d;
        y_pos      <= y_pos_d;
        y_vel      <= y_vel_d;
        state      <= state_d;
        airborne_q <= (state_d != GROUND);
      end
    end
  end

  assign bus.player_X_Pos    = x_pos;
  assign bus.player_Y_Pos    = y_pos;
  assign bus.player_X_Motion = x_vel;
  assign bus.player_Y_Motion = y_vel;
  assign bus.airborne        = airborne_q;
  assign bus.at_wall         = at_wall_q;
  assign bus.y_state         = state;

endmodule

// File: tb/tb_player_motion.sv
// Bench for player_motion: directed test-plan sequences plus random keycodes,
// each frame tick compared against an integer reference model.
module tb_player_motion;
  localparam int W = 10;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  logic frame_clk = 1'b0;

  player_motion_if #(.W(W)) bus ();

  player_motion #(.W(W)) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .frame_clk (frame_clk),
    .bus       (bus.slave)
  );

  // ---------------- clock / reset ----------------
  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  // Reference model: playfield 4..635 in X, ceiling 4, ground 475.
  int m_x, m_y, m_vx, m_vy;
  bit m_air, m_up, m_wall;

  task automatic model_reset();
    m_x = 320; m_y = 475; m_vx = 0; m_vy = 0;
    m_air = 0; m_up = 0; m_wall = 0;
  endtask

  task automatic model_step(input int key);
    int nx, ny;
    if (key == 80)      m_vx = (m_vx - 1 < -4) ? -4 : m_vx - 1;
    else if (key == 79) m_vx = (m_vx + 1 > 4) ? 4 : m_vx + 1;
    else if (m_vx > 0)  m_vx = m_vx - 1;
    else if (m_vx < 0)  m_vx = m_vx + 1;
    nx = m_x + m_vx;
    if (nx < 4)        begin m_x = 4;   m_vx = 0; m_wall = 1; end
    else if (nx > 635) begin m_x = 635; m_vx = 0; m_wall = 1; end
    else               begin m_x = nx;  m_wall = 0; end

    if (!m_air) begin
      if (key == 82) begin m_vy = -8; m_y = 467; m_air = 1; m_up = 1; end
    end else if (m_up) begin
      m_vy = m_vy + 1;
      ny = m_y + m_vy;
      if (ny < 4) begin m_y = 4; m_vy = 0; m_up = 0; end
      else begin m_y = ny; if (m_vy >= 0) m_up = 0; end
    end else begin
      m_vy = (m_vy + 1 > 8) ? 8 : m_vy + 1;
      ny = m_y + m_vy;
      if (ny >= 475) begin m_y = 475; m_vy = 0; m_air = 0; end
      else m_y = ny;
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input int got, input int exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".x"},    int'(bus.player_X_Pos), m_x);
    chk({tag, ".y"},    int'(bus.player_Y_Pos), m_y);
    chk({tag, ".vx"},   int'($signed(bus.player_X_Motion)), m_vx);
    chk({tag, ".vy"},   int'($signed(bus.player_Y_Motion)), m_vy);
    chk({tag, ".air"},  int'(bus.airborne), int'(m_air));
    chk({tag, ".wall"}, int'(bus.at_wall), int'(m_wall));
  endtask

  // ---------------- drivers ----------------
  task automatic frame_tick(input logic [7:0] key);
    @(negedge Clk);
    bus.keycode = key;
    frame_clk = 1'b1;
    repeat (3) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (3) @(negedge Clk);
    model_step(int'(key));
  endtask

  task automatic do_reset(input logic [7:0] key);
    @(negedge Clk);
    #2 Reset_n = 1'b0;
    #1;
    model_reset();
    check_all("reset_async");
    @(negedge Clk);
    bus.keycode = key;
    Reset_n = 1'b1;
    repeat (4) @(negedge Clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int xs_right[6] = '{321, 323, 326, 330, 334, 338};
    int vs_right[6] = '{1, 2, 3, 4, 4, 4};
    int xs_rel[4]   = '{341, 343, 344, 344};
    int vs_rel[4]   = '{3, 2, 1, 0};
    int ys_jump[17] = '{467, 460, 454, 449, 445, 442, 440, 439, 439,
                        440, 442, 445, 449, 454, 460, 467, 475};
    logic [W-1:0] e;
    bus.keycode = 8'd0;
    model_reset();
    repeat (3) @(negedge Clk);
    #2;
    check_all("reset_hold");
    Reset_n = 1'b1;
    repeat (4) @(negedge Clk);
    check_all("after_release");

    // Accelerate right, then release.
    foreach (xs_right[i]) exp_q.push_back(W'(xs_right[i]));
    for (int i = 0; i < 6; i++) begin
      frame_tick(8'd79);
      e = exp_q.pop_front();
      chk("right.x_tbl", int'(bus.player_X_Pos), int'(e));
      chk("right.vx_tbl", int'($signed(bus.player_X_Motion)), vs_right[i]);
      check_all("right");
    end
    for (int i = 0; i < 4; i++) begin
      frame_tick(8'd0);
      chk("release.x_tbl", int'(bus.player_X_Pos), xs_rel[i]);
      chk("release.vx_tbl", int'($signed(bus.player_X_Motion)), vs_rel[i]);
      check_all("release");
    end

    // Single jump: one tick with the jump key, then idle.
    for (int i = 0; i < 17; i++) begin
      frame_tick((i == 0) ? 8'd82 : 8'd0);
      chk("jump.y_tbl", int'(bus.player_Y_Pos), ys_jump[i]);
      chk("jump.air_tbl", int'(bus.airborne), (i < 16) ? 1 : 0);
      if (i == 0) chk("jump.vy_first", int'($signed(bus.player_Y_Motion)), -8);
      check_all("jump");
    end

    // Left wall from reset.
    do_reset(8'd0);
    check_all("wall_start");
    for (int i = 1; i <= 84; i++) begin
      frame_tick(8'd80);
      if (i == 80) chk("wall.x80", int'(bus.player_X_Pos), 6);
      if (i == 81) begin
        chk("wall.x81", int'(bus.player_X_Pos), 4);
        chk("wall.flag81", int'(bus.at_wall), 1);
        chk("wall.vx81", int'($signed(bus.player_X_Motion)), 0);
      end
      check_all("wall");
    end
    frame_tick(8'd0);
    chk("wall.release_flag", int'(bus.at_wall), 0);
    check_all("wall_release");

    // frame_clk held high for 100 cycles yields exactly one tick.
    @(negedge Clk);
    bus.keycode = 8'd79;
    frame_clk = 1'b1;
    repeat (100) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (3) @(negedge Clk);
    model_step(79);
    check_all("long_frame");

    // Reset in the middle of a rise.
    frame_tick(8'd82);
    frame_tick(8'd0);
    frame_tick(8'd0);
    check_all("mid_rise");
    do_reset(8'd82);
    check_all("mid_rise_reset");

    // Jump key held through reset release: jump on the first tick.
    frame_tick(8'd82);
    chk("first_tick_jump.y", int'(bus.player_Y_Pos), 467);
    check_all("first_tick_jump");

    // frame_clk already high at reset release must not tick.
    @(negedge Clk);
    Reset_n = 1'b0;
    frame_clk = 1'b1;
    bus.keycode = 8'd79;
    model_reset();
    @(negedge Clk);
    Reset_n = 1'b1;
    repeat (10) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (3) @(negedge Clk);
    check_all("high_at_release");

    // Random keycodes.
    for (int i = 0; i < 300; i++) begin
      int r;
      logic [7:0] k;
      r = int'($urandom_range(0, 9));
      if (r <= 2)      k = 8'd79;
      else if (r <= 5) k = 8'd80;
      else if (r <= 7) k = 8'd82;
      else if (r == 8) k = 8'd0;
      else             k = 8'($urandom_range(0, 255));
      frame_tick(k);
      check_all("random");
    end

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
